// File: rtl/systolic_seq_ctrl_if.sv
// Job configuration handshake between the job source and the systolic tile sequencer.
interface systolic_seq_ctrl_if #(
  parameter int unsigned KW = 16
) ();
  logic          cfg_valid;
  logic          cfg_ready;
  logic [KW-1:0] cfg_k;
  logic [2:0]    cfg_type;

  modport master (output cfg_valid, output cfg_k, output cfg_type, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_k, input cfg_type, output cfg_ready);
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for an N x N systolic array: clear, skewed stream, row drain, done pulse.
// Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.
module systolic_seq_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned KW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_seq_ctrl_if.slave   cfg,
  output logic [2:0]           type_out,
  input  logic                 src_stall,
  output logic                 fetch_en,
  output logic [KW-1:0]        fetch_idx,
  output logic [N-1:0]         row_en,
  output logic [N-1:0]         col_en,
  output logic                 acc_clr,
  output logic                 drain_en,
  output logic [$clog2(N)-1:0] drain_row,
  output logic                 busy,
  output logic                 done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          job_cycles
`endif
);

  // One extra bit so K + 2N - 3 never wraps.
  localparam int unsigned TW = KW + 1;
  localparam int unsigned RW = $clog2(N);

  typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StDone} state_e;

  state_e        state_q;
  logic [TW-1:0] t_q;
  logic [KW-1:0] k_q;
  logic [2:0]    type_q;
  logic [RW-1:0] drow_q;
  logic          ready_q, clr_q, busy_q, done_q, drain_q;

  logic [TW-1:0] k_ext, t_last;
  logic          accept, stream_go;

  assign k_ext     = {1'b0, k_q};
  assign t_last    = k_ext + TW'(2 * N - 3);
  assign accept    = cfg.cfg_valid && ready_q;
  assign stream_go = (state_q == StStream) && !src_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      k_q     <= '0;
      type_q  <= '0;
      drow_q  <= '0;
      ready_q <= 1'b1;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            k_q     <= cfg.cfg_k;
            type_q  <= cfg.cfg_type;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (cfg.cfg_k == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StLoad;
              clr_q   <= 1'b1;
            end
          end
        end
        StLoad: begin
          t_q     <= '0;
          state_q <= StStream;
        end
        StStream: begin
          if (!src_stall) begin
            if (t_q == t_last) begin
              state_q <= StDrain;
              drain_q <= 1'b1;
              drow_q  <= '0;
            end else begin
              t_q <= t_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drow_q == RW'(N - 1)) begin
            drain_q <= 1'b0;
            drow_q  <= '0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            drow_q <= drow_q + 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Skewed wavefront: edge lane i is live for t in [i, i+K).
  always_comb begin
    row_en = '0;
    for (int i = 0; i < N; i++) begin
      row_en[i] = stream_go && (t_q >= TW'(i)) && (t_q < k_ext + TW'(i));
    end
  end

  assign col_en        = row_en;
  assign fetch_en      = stream_go && (t_q < k_ext);
  assign fetch_idx     = fetch_en ? t_q[KW-1:0] : '0;
  assign cfg.cfg_ready = ready_q;
  assign type_out      = type_q;
  assign acc_clr       = clr_q;
  assign drain_en      = drain_q;
  assign drain_row     = drow_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_q, cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      cyc_q   <= '0;
    end else if (accept) begin
      stall_q <= '0;
      cyc_q   <= '0;
    end else begin
      if ((state_q == StStream) && src_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if ((state_q != StIdle) && (cyc_q != '1)) cyc_q <= cyc_q + 1'b1;
    end
  end

  assign stall_cnt  = stall_q;
  assign job_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: an N=4/KW=16 instance for timing and an
// N=8/KW=4 instance for the maximum-depth case.
module tb_systolic_seq_ctrl;

  logic clk, rst;
  int   n_checks, n_pass;

  systolic_seq_ctrl_if #(.KW(16)) a_if ();
  systolic_seq_ctrl_if #(.KW(4))  b_if ();

  logic [2:0]  a_type, b_type;
  logic        a_stall, b_stall;
  logic        a_fe, b_fe;
  logic [15:0] a_fidx;
  logic [3:0]  b_fidx;
  logic [3:0]  a_row, a_col;
  logic [7:0]  b_row, b_col;
  logic        a_clr, b_clr, a_den, b_den, a_busy, b_busy, a_done, b_done;
  logic [1:0]  a_drow;
  logic [2:0]  b_drow;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] a_stall_cnt, a_job_cycles, b_stall_cnt, b_job_cycles;
`endif

  systolic_seq_ctrl #(.N(4), .KW(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .cfg       (a_if),
    .type_out  (a_type),
    .src_stall (a_stall),
    .fetch_en  (a_fe),
    .fetch_idx (a_fidx),
    .row_en    (a_row),
    .col_en    (a_col),
    .acc_clr   (a_clr),
    .drain_en  (a_den),
    .drain_row (a_drow),
    .busy      (a_busy),
    .done      (a_done)
`ifdef SEQ_PERF_CNT_EN
    ,
    .stall_cnt (a_stall_cnt),
    .job_cycles(a_job_cycles)
`endif
  );

  systolic_seq_ctrl #(.N(8), .KW(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .cfg       (b_if),
    .type_out  (b_type),
    .src_stall (b_stall),
    .fetch_en  (b_fe),
    .fetch_idx (b_fidx),
    .row_en    (b_row),
    .col_en    (b_col),
    .acc_clr   (b_clr),
    .drain_en  (b_den),
    .drain_row (b_drow),
    .busy      (b_busy),
    .done      (b_done)
`ifdef SEQ_PERF_CNT_EN
    ,
    .stall_cnt (b_stall_cnt),
    .job_cycles(b_job_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    logic [31:0] obs;
    rst = 1'b0;
    #1;
    obs = {a_if.cfg_ready, a_busy, a_clr, a_done, a_den, a_drow, a_fe, a_fidx, a_col, a_row};
    n_checks++;
    if (obs !== 32'h8000_0000) $display("FAIL reset_a got=%h exp=%h", obs, 32'h8000_0000);
    else n_pass++;
    n_checks++;
    if ({b_if.cfg_ready, b_busy, b_done, b_den, b_fe, b_row, b_col} !== 21'h10_0000)
      $display("FAIL reset_b got=%h exp=%h", {b_if.cfg_ready, b_busy, b_done, b_den, b_fe,
               b_row, b_col}, 21'h10_0000);
    else n_pass++;
    n_checks++;
    if (a_type !== 3'd0) $display("FAIL reset_type got=%0d exp=0", a_type);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic(input string name);
    logic [3:0]  row_tab [0:17] = '{4'd0, 4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8,
                                    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [31:0] obs, exp;
    logic        fe, den;
    logic [15:0] idx;
    logic [1:0]  drow;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      a_if.cfg_valid = (c == 0);
      a_if.cfg_k     = 16'd4;
      a_if.cfg_type  = 3'd5;
      a_stall        = 1'b0;
      #1;
      fe   = (c >= 2) && (c <= 5);
      idx  = fe ? 16'(c - 2) : 16'd0;
      den  = (c >= 12) && (c <= 15);
      drow = den ? 2'(c - 12) : 2'd0;
      exp  = {(c == 0) || (c == 17), (c >= 1) && (c <= 16), c == 1, c == 16, den, drow, fe, idx,
              row_tab[c], row_tab[c]};
      obs  = {a_if.cfg_ready, a_busy, a_clr, a_done, a_den, a_drow, a_fe, a_fidx, a_col, a_row};
      n_checks++;
      if (obs !== exp) $display("FAIL %s c=%0d got=%h exp=%h", name, c, obs, exp);
      else n_pass++;
    end
    n_checks++;
    if (a_type !== 3'd5) $display("FAIL %s_type got=%0d exp=5", name, a_type);
    else n_pass++;
`ifdef SEQ_PERF_CNT_EN
    n_checks++;
    if ({a_stall_cnt, a_job_cycles} !== {32'd0, 32'd16})
      $display("FAIL %s_perf got=%0d,%0d exp=0,16", name, a_stall_cnt, a_job_cycles);
    else n_pass++;
`endif
  endtask

  task automatic test_stall();
    logic [3:0]  row_tab [0:19] = '{4'd0, 4'd0, 4'd1, 4'd3, 4'd0, 4'd0, 4'd7, 4'd15, 4'd14,
                                    4'd12, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                                    4'd0, 4'd0};
    logic [31:0] obs, exp;
    logic        fe, den;
    logic [15:0] idx;
    logic [1:0]  drow;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_if.cfg_valid = (c == 0);
      a_if.cfg_k     = 16'd4;
      a_if.cfg_type  = 3'd4;
      a_stall        = (c == 4) || (c == 5);
      #1;
      fe   = (c == 2) || (c == 3) || (c == 6) || (c == 7);
      idx  = (c == 3) ? 16'd1 : (c == 6) ? 16'd2 : (c == 7) ? 16'd3 : 16'd0;
      den  = (c >= 14) && (c <= 17);
      drow = den ? 2'(c - 14) : 2'd0;
      exp  = {(c == 0) || (c == 19), (c >= 1) && (c <= 18), c == 1, c == 18, den, drow, fe, idx,
              row_tab[c], row_tab[c]};
      obs  = {a_if.cfg_ready, a_busy, a_clr, a_done, a_den, a_drow, a_fe, a_fidx, a_col, a_row};
      n_checks++;
      if (obs !== exp) $display("FAIL stall c=%0d got=%h exp=%h", c, obs, exp);
      else n_pass++;
    end
    a_stall = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    n_checks++;
    if ({a_stall_cnt, a_job_cycles} !== {32'd2, 32'd18})
      $display("FAIL stall_perf got=%0d,%0d exp=2,18", a_stall_cnt, a_job_cycles);
    else n_pass++;
`endif
  endtask

  task automatic test_k0();
    logic [31:0] obs, exp;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_if.cfg_valid = (c == 0);
      a_if.cfg_k     = 16'd0;
      a_if.cfg_type  = 3'd3;
      #1;
      exp = (c == 1) ? 32'h5000_0000 : 32'h8000_0000;
      obs = {a_if.cfg_ready, a_busy, a_clr, a_done, a_den, a_drow, a_fe, a_fidx, a_col, a_row};
      n_checks++;
      if (obs !== exp) $display("FAIL k0 c=%0d got=%h exp=%h", c, obs, exp);
      else n_pass++;
    end
    n_checks++;
    if (a_type !== 3'd3) $display("FAIL k0_type got=%0d exp=3", a_type);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs, exp;
    for (int c = 0; c < 29; c++) begin
      @(negedge clk);
      a_if.cfg_valid = (c <= 14);
      a_if.cfg_k     = 16'd1;
      a_if.cfg_type  = (c == 0) ? 3'd2 : 3'd6;
      #1;
      if (c >= 1) begin
        exp = {(c == 14) || (c == 28), (c == 13) || (c == 27), (c == 1) || (c == 15),
               (c >= 15) ? 3'd6 : 3'd2};
        obs = {a_if.cfg_ready, a_done, a_clr, a_type};
        n_checks++;
        if (obs !== exp) $display("FAIL b2b c=%0d got=%b exp=%b", c, obs, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] obs;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_if.cfg_valid = (c == 0);
      a_if.cfg_k     = 16'd4;
      a_if.cfg_type  = 3'd7;
    end
    #2;
    rst = 1'b0;
    #1;
    obs = {a_if.cfg_ready, a_busy, a_clr, a_done, a_den, a_drow, a_fe, a_fidx, a_col, a_row};
    n_checks++;
    if ({obs, a_type} !== {32'h8000_0000, 3'd0})
      $display("FAIL async_rst got=%h/%0d exp=80000000/0", obs, a_type);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_if.cfg_ready, a_busy, a_done} !== 3'b100)
        $display("FAIL post_rst c=%0d got=%b exp=100", c, {a_if.cfg_ready, a_busy, a_done});
      else n_pass++;
    end
  endtask

  task automatic test_kmax();
    logic [5:0] obs, exp;
    logic [2:0] drow;
    logic [19:0] eobs, eexp;
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      b_if.cfg_valid = (c == 0);
      b_if.cfg_k     = 4'd15;
      b_if.cfg_type  = 3'd1;
      #1;
      drow = ((c >= 31) && (c <= 38)) ? 3'(c - 31) : 3'd0;
      exp  = {(c >= 31) && (c <= 38), c == 39, (c >= 2) && (c <= 16), drow};
      obs  = {b_den, b_done, b_fe, b_drow};
      n_checks++;
      if (obs !== exp) $display("FAIL kmax c=%0d got=%b exp=%b", c, obs, exp);
      else n_pass++;
      if (c == 2 || c == 3 || c == 9 || c == 16 || c == 23 || c == 24 || c == 30) begin
        case (c)
          2:       eexp = {4'd0, 8'h01, 8'h01};
          3:       eexp = {4'd1, 8'h03, 8'h03};
          9:       eexp = {4'd7, 8'hFF, 8'hFF};
          16:      eexp = {4'd14, 8'hFF, 8'hFF};
          23:      eexp = {4'd0, 8'h80, 8'h80};
          default: eexp = 20'd0;
        endcase
        eobs = {b_fidx, b_row, b_col};
        n_checks++;
        if (eobs !== eexp) $display("FAIL kmax_en c=%0d got=%h exp=%h", c, eobs, eexp);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    a_if.cfg_valid = 1'b0;
    a_if.cfg_k     = '0;
    a_if.cfg_type  = '0;
    b_if.cfg_valid = 1'b0;
    b_if.cfg_k     = '0;
    b_if.cfg_type  = '0;
    a_stall        = 1'b0;
    b_stall        = 1'b0;
    rst            = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic("basic");
    test_stall();
    test_k0();
    test_back_to_back();
    test_async_reset();
    test_basic("after_rst");
    test_kmax();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Tile-level sequencer for the N x N systolic PE array. Accepts one matrix-tile job (depth K, compute type) over a valid/ready handshake and clears the PE accumulators. It then drives the skewed per-row (left edge) and per-column (top edge) enables while the operand buffers stream A/B, waits for the wavefront to reach PE(N-1,N-1), drains the accumulated sums row by row, and pulses done. Sits between the job/operand-buffer control and the PE array edge enable/compute-mode inputs.

Parameters:
N, 8, array dimension (rows = columns); N >= 2
KW, 16, width of the K (reduction depth) field and the fetch index

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
cfg_valid  in  1  job request
cfg_ready  out  1  controller can accept a job
cfg_k  in  KW  reduction depth K, sampled on accept
cfg_type  in  3  compute type, sampled on accept
type_out  out  3  latched compute type, drives the array compute_type input
src_stall  in  1  operand buffers not ready this cycle
fetch_en  out  1  request one A column / B row from the buffers
fetch_idx  out  KW  index of the operand slice requested
row_en  out  N  left-edge enable, one bit per PE row
col_en  out  N  top-edge enable, one bit per PE column
acc_clr  out  1  one-cycle clear of the PE accumulators
drain_en  out  1  array shifts out one row of sums
drain_row  out  clog2(N)  index of the row being drained
busy  out  1  job in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all counters 0, type_out=0. Every output is 0 except cfg_ready. A job in flight is abandoned with no done.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE: cfg_ready=1. Accept occurs when cfg_valid&&cfg_ready. On accept, latch K and type_out. If K=0, go to DONE; otherwise go to LOAD.
- LOAD: one cycle, acc_clr=1, busy=1. Clear t. Go to STREAM.
- STREAM: busy=1. Stream counter t runs 0..K+2N-3, giving K+2N-2 non-stalled cycles.
  - row_en[i] = !src_stall && (i <= t < i+K)
  - col_en[j] = !src_stall && (j <= t < j+K)
  - fetch_en = !src_stall && t < K
  - fetch_idx = t; hold 0 when fetch_en=0
  - These outputs are combinational from registered t and src_stall.
  - src_stall=1 freezes t and forces all enables and fetch_en to 0.
  - When t = K+2N-3 and the cycle is not stalled, go to DRAIN.
- DRAIN: busy=1. Runs exactly N cycles with drain_en=1 and drain_row = 0..N-1. src_stall is ignored. After the last row, go to DONE.
- DONE: one cycle, done=1 and busy=1. Go to IDLE. cfg_ready is 0 in every state except IDLE, so back-to-back jobs are separated by at least one IDLE cycle.
- t is KW+1 bits wide so that K+2N-3 cannot wrap for K up to 2^KW-1.
- type_out holds its value until the next accept.
- cfg_valid while busy: no effect; the request is held off by cfg_ready=0.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined: adds outputs stall_cnt (32 bits) and job_cycles (32 bits).
  - stall_cnt counts STREAM cycles with src_stall=1.
  - job_cycles counts cycles from LOAD through DONE inclusive.
  - Both clear on accept and saturate at 2^32-1.
  - Both hold their value after done until the next accept; both reset to 0.
- When undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- N=4, K=4, accept at cycle 0, no stall:
  - acc_clr at cycle 1; STREAM cycles 2-11.
  - row_en[0] high cycles 2-5; row_en[3] high cycles 5-8.
  - fetch_idx 0..3 on cycles 2-5.
  - drain_row 0..3 on cycles 12-15; done at cycle 16; cfg_ready back at cycle 17.
- Same job with src_stall=1 on cycles 4-5:
  - All enables 0 on cycles 4-5; fetch_idx resumes at 2 on cycle 6.
  - Done at cycle 18; stall_cnt=2 and job_cycles=18 with SEQ_PERF_CNT_EN.
- K=0 accept:
  - No acc_clr, no row_en/col_en, no drain_en.
  - Done one cycle after accept.
- cfg_valid held high throughout a job:
  - Second job accepted only on the first IDLE cycle after done.
  - type_out switches only at that accept.
- rst=0 asserted mid-STREAM (asynchronous, between clock edges):
  - All outputs 0 immediately and cfg_ready=1; no done pulse.
  - Next job runs with full timing.
- K=2^KW-1, N=8:
  - t reaches K+13 without wrap.
  - Total STREAM length K+14 cycles.
